// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, PC enable and memory requests
// for a 5-stage pipeline, with load-use, redirect, cache-wait and halt handling.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             redirect,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             halt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic active;
   logic mem_req;
   logic freeze;
   logic load_use;

   assign active   = ~RST & (state_q != HALTED);
   assign mem_req  = exmem_memread | exmem_memwrite;
   assign freeze   = mem_req & ~dhit;
   assign load_use = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

   // Next state, stage controls and counter updates from state + inputs
   always_comb begin
      state_d     = state_q;
      cycle_d     = cycle_q;
      stall_d     = stall_q;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      imemREN     = 1'b0;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
      halt        = ~RST & (state_q == HALTED);

      case (state_q)
         RUN: begin
            if (wb_halt)     state_d = HALTED;
            else if (freeze) state_d = DWAIT;
         end
         DWAIT: begin
            if (dhit) state_d = RUN;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase

      if (active) begin
         imemREN = 1'b1;
         dmemREN = exmem_memread;
         dmemWEN = exmem_memwrite;

         if (freeze) begin
            // Whole pipe holds; a pending redirect re-presents once EX/MEM moves
            pc_en = 1'b0;
         end else if (redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (load_use) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (~ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end

         cycle_d = cycle_q + CNT_W'(1);
         if (!pc_en) stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         cycle_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
      end
   end

   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_q;

endmodule
